dispatch_unit: RTL and testbench
================================

Name: dispatch_unit

Overview:
- Parametrised successor of the in-order dispatcher, placed between the decoder and the issue queues (RS and LSB). Accepts one pre-decoded instruction per cycle over a valid/ready handshake.
- Allocates a ROB entry and renames rd in the register status table. Resolves source operands from the regfile, the ROB and N same-cycle CDB broadcasts.
- Holds the result in a single output slot that keeps snooping the CDB while stalled on a full RS or LSB. Supports flush.

Parameters:
XLEN, 32, data/pc/imm width
TAG_W, 4, ROB tag width; tag 0 = "no dependency / value ready"
OPT_W, 6, optype width
NUM_CDB, 2, number of CDB broadcast channels snooped

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  mispredict flush; kills held slot
dec_valid  in  1  decoded instruction valid
dec_ready  out  1  dispatcher accepts this cycle
dec_pc  in  XLEN  instruction pc
dec_optype  in  OPT_W  operation type
dec_is_ls  in  1  1 = route to LSB, 0 = route to RS
dec_rd  in  5  destination register
dec_has_rd  in  1  instruction writes rd
dec_rs1, dec_rs2  in  5 each  source registers
dec_imm  in  XLEN  immediate
rf_rs1, rf_rs2  out  5 each  regfile lookup addresses (= dec_rs1/2, combinational)
rf_q1, rf_q2  in  TAG_W each  rename tags from regfile
rf_v1, rf_v2  in  XLEN each  regfile values
rob_q1, rob_q2  out  TAG_W each  ROB lookup tags (= rf_q1/2)
rob_rdy1, rob_rdy2  in  1 each  ROB entry already has its result
rob_v1, rob_v2  in  XLEN each  ROB result values
rob_full  in  1  ROB cannot allocate
rob_alloc  out  1  allocate ROB entry (= accept)
rob_alloc_tag  in  TAG_W  tag of entry being allocated (never 0)
ren_en  out  1  write rename tag for rd
ren_rd  out  5  register being renamed
ren_tag  out  TAG_W  new tag (= rob_alloc_tag)
cdb_valid  in  NUM_CDB  per-channel broadcast valid
cdb_tag  in  NUM_CDB*TAG_W  channel i at bits [i*TAG_W +: TAG_W]
cdb_val  in  NUM_CDB*XLEN  channel i at bits [i*XLEN +: XLEN]
rs_ready, lsb_ready  in  1 each  queue can accept this cycle
out_valid_rs, out_valid_lsb  out  1 each  held slot is offered to RS or LSB
out_optype  out  OPT_W  held optype
out_pc, out_imm  out  XLEN each  held pc / immediate
out_qj, out_qk  out  TAG_W each  pending tags (0 = ready)
out_vj, out_vk  out  XLEN each  operand values
out_dest  out  TAG_W  ROB tag of the instruction

Behaviour:
- State: slot EMPTY or FULL; held fields are registers.
  - fire = FULL & (is_ls ? lsb_ready : rs_ready).
  - out_valid_lsb = FULL & is_ls; out_valid_rs = FULL & !is_ls.
- Handshake:
  - dec_ready = !flush & !rob_full & (EMPTY | fire). accept = dec_valid & dec_ready.
  - Accept and fire in the same cycle: the slot reloads and stays FULL, giving zero-bubble throughput of 1 instruction/cycle.
- Accept effects, all in the same cycle:
  - rob_alloc = 1.
  - ren_en = dec_has_rd & (dec_rd != 0); x0 is never renamed.
  - Slot loads at the clock edge, with out_dest = rob_alloc_tag.
- Operand resolution at accept, per source, first match wins:
  1. rf_q = 0 → value rf_v, tag 0.
  2. Any CDB channel valid with tag = rf_q → that channel's value, tag 0; the lowest channel index wins.
  3. rob_rdy → rob_v, tag 0.
  4. Otherwise keep tag rf_q, value 0.
- Held-slot wakeup:
  - While FULL and not replaced, each operand with tag ≠ 0 that matches a valid CDB channel takes the value and its tag becomes 0 at the next edge; lowest channel wins.
  - Applies in the same cycle as an out_valid offer. The consumer sees the pre-edge values, and the RS/LSB does its own CDB snoop that cycle.
- Flush: at the next edge slot → EMPTY. No accept, rob_alloc or ren_en during a flush cycle. Flush overrides fire.
- rdy-style pause is not handled here; upstream deasserts dec_valid.
- Reset: slot EMPTY. All out_* registers 0, out_valid_* = 0. dec_ready is low during rst. Reset mid-stall drops the held instruction.
- Latency: accept at edge N → offered to RS/LSB in cycle N+1.

Test Plan:
- Reset, then ALU op with rf_q1 = rf_q2 = 0, rf_v1 = 5, rf_v2 = 7, rob_alloc_tag = 3, dec_rd = 4 → ren_en = 1, ren_rd = 4, ren_tag = 3. Next cycle out_valid_rs = 1, out_vj = 5, out_vk = 7, out_qj = out_qk = 0, out_dest = 3.
- Load with rf_q1 = 2, rob_rdy1 = 0, rs_ready = 1, lsb_ready = 0 for 3 cycles → out_valid_lsb stays 1, out_qj = 2, dec_ready = 0. CDB ch1 broadcasts tag 2, value 0x99 → next cycle out_qj = 0, out_vj = 0x99. Raise lsb_ready → fires, slot empties.
- Same-cycle forwarding: rf_q1 = 6 while cdb ch0 has tag 6, value 0x11, and rob_rdy1 = 1 with rob_v1 = 0x22 → out_vj = 0x11, out_qj = 0. Both channels carry tag 6 → ch0 value used.
- Back-to-back: 4 ALU ops with rs_ready held at 1 → 4 consecutive out_valid_rs cycles, dec_ready always 1. rob_full = 1 → dec_ready = 0, and no rob_alloc or ren_en.
- Instruction with dec_rd = 0, dec_has_rd = 1 → ren_en = 0, rob_alloc = 1.
- Flush while stalled FULL, with dec_valid = 1 that cycle → next cycle slot EMPTY, no ren_en in the flush cycle. Assert rst while FULL → all outputs 0 next cycle.

Source files
------------

// File: rtl/dispatch_unit.sv
// Dispatch stage: renames rd, allocates a ROB entry, resolves operands and
// holds one instruction for the RS or the LSB while it snoops the CDB.
//
// Ports:
//   clk, rst (sync, active-high), flush
//   dec_*              : decoded instruction in, dec_ready back-pressure
//   rf_* / rob_*       : operand lookups, ROB allocation
//   ren_*              : rename write for rd
//   cdb_*              : NUM_CDB packed broadcast channels
//   rs_ready/lsb_ready : queue back-pressure
//   out_*              : held slot offered to RS or LSB
module dispatch_unit #(
  parameter int XLEN    = 32,
  parameter int TAG_W   = 4,
  parameter int OPT_W   = 6,
  parameter int NUM_CDB = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     dec_valid,
  output logic                     dec_ready,
  input  logic [XLEN-1:0]          dec_pc,
  input  logic [OPT_W-1:0]         dec_optype,
  input  logic                     dec_is_ls,
  input  logic [4:0]               dec_rd,
  input  logic                     dec_has_rd,
  input  logic [4:0]               dec_rs1,
  input  logic [4:0]               dec_rs2,
  input  logic [XLEN-1:0]          dec_imm,
  output logic [4:0]               rf_rs1,
  output logic [4:0]               rf_rs2,
  input  logic [TAG_W-1:0]         rf_q1,
  input  logic [TAG_W-1:0]         rf_q2,
  input  logic [XLEN-1:0]          rf_v1,
  input  logic [XLEN-1:0]          rf_v2,
  output logic [TAG_W-1:0]         rob_q1,
  output logic [TAG_W-1:0]         rob_q2,
  input  logic                     rob_rdy1,
  input  logic                     rob_rdy2,
  input  logic [XLEN-1:0]          rob_v1,
  input  logic [XLEN-1:0]          rob_v2,
  input  logic                     rob_full,
  output logic                     rob_alloc,
  input  logic [TAG_W-1:0]         rob_alloc_tag,
  output logic                     ren_en,
  output logic [4:0]               ren_rd,
  output logic [TAG_W-1:0]         ren_tag,
  input  logic [NUM_CDB-1:0]       cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
  input  logic [NUM_CDB*XLEN-1:0]  cdb_val,
  input  logic                     rs_ready,
  input  logic                     lsb_ready,
  output logic                     out_valid_rs,
  output logic                     out_valid_lsb,
  output logic [OPT_W-1:0]         out_optype,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_imm,
  output logic [TAG_W-1:0]         out_qj,
  output logic [TAG_W-1:0]         out_qk,
  output logic [XLEN-1:0]          out_vj,
  output logic [XLEN-1:0]          out_vk,
  output logic [TAG_W-1:0]         out_dest
);

  typedef enum logic {EMPTY, FULL} state_t;

  typedef struct packed {
    logic [TAG_W-1:0] q;
    logic [XLEN-1:0]  v;
  } opnd_t;

  typedef struct packed {
    logic             is_ls;
    logic [OPT_W-1:0] optype;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  imm;
    opnd_t            j;
    opnd_t            k;
    logic [TAG_W-1:0] dest;
  } slot_t;

  state_t state_q, state_d;
  slot_t  slot_q, slot_d;
  opnd_t  res_j, res_k;
  logic   full, fire, accept;

  // Iterating from the top channel down lets channel 0 win ties.
  function automatic opnd_t snoop(
    input opnd_t                    o,
    input logic [NUM_CDB-1:0]       cv,
    input logic [NUM_CDB*TAG_W-1:0] ct,
    input logic [NUM_CDB*XLEN-1:0]  cval
  );
    opnd_t r;
    r = o;
    if (o.q != '0) begin
      for (int i = NUM_CDB - 1; i >= 0; i--) begin
        if (cv[i] && ct[i*TAG_W +: TAG_W] == o.q) begin
          r.q = '0;
          r.v = cval[i*XLEN +: XLEN];
        end
      end
    end
    return r;
  endfunction

  // Priority: regfile value, then CDB, then ROB, else stay pending.
  function automatic opnd_t resolve(
    input logic [TAG_W-1:0]         q,
    input logic [XLEN-1:0]          rfv,
    input logic                     rdy,
    input logic [XLEN-1:0]          robv,
    input logic [NUM_CDB-1:0]       cv,
    input logic [NUM_CDB*TAG_W-1:0] ct,
    input logic [NUM_CDB*XLEN-1:0]  cval
  );
    opnd_t r;
    r.q = q;
    r.v = '0;
    if (q == '0) begin
      r.v = rfv;
    end else begin
      if (rdy) begin
        r.q = '0;
        r.v = robv;
      end
      for (int i = NUM_CDB - 1; i >= 0; i--) begin
        if (cv[i] && ct[i*TAG_W +: TAG_W] == q) begin
          r.q = '0;
          r.v = cval[i*XLEN +: XLEN];
        end
      end
    end
    return r;
  endfunction

  assign full   = (state_q == FULL);
  assign fire   = full & (slot_q.is_ls ? lsb_ready : rs_ready);
  assign dec_ready = !rst & !flush & !rob_full & (!full | fire);
  assign accept = dec_valid & dec_ready;

  assign rf_rs1 = dec_rs1;
  assign rf_rs2 = dec_rs2;
  assign rob_q1 = rf_q1;
  assign rob_q2 = rf_q2;

  assign rob_alloc = accept;
  assign ren_en    = accept & dec_has_rd & (dec_rd != 5'd0);
  assign ren_rd    = dec_rd;
  assign ren_tag   = rob_alloc_tag;

  always_comb begin
    res_j = resolve(rf_q1, rf_v1, rob_rdy1, rob_v1,
                    cdb_valid, cdb_tag, cdb_val);
    res_k = resolve(rf_q2, rf_v2, rob_rdy2, rob_v2,
                    cdb_valid, cdb_tag, cdb_val);
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    if (flush) begin
      state_d = EMPTY;
    end else if (accept) begin
      state_d       = FULL;
      slot_d.is_ls  = dec_is_ls;
      slot_d.optype = dec_optype;
      slot_d.pc     = dec_pc;
      slot_d.imm    = dec_imm;
      slot_d.j      = res_j;
      slot_d.k      = res_k;
      slot_d.dest   = rob_alloc_tag;
    end else if (fire) begin
      state_d = EMPTY;
    end else if (full) begin
      slot_d.j = snoop(slot_q.j, cdb_valid, cdb_tag, cdb_val);
      slot_d.k = snoop(slot_q.k, cdb_valid, cdb_tag, cdb_val);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
    end
  end

  assign out_valid_rs  = full & !slot_q.is_ls;
  assign out_valid_lsb = full & slot_q.is_ls;
  assign out_optype    = slot_q.optype;
  assign out_pc        = slot_q.pc;
  assign out_imm       = slot_q.imm;
  assign out_qj        = slot_q.j.q;
  assign out_qk        = slot_q.k.q;
  assign out_vj        = slot_q.j.v;
  assign out_vk        = slot_q.k.v;
  assign out_dest      = slot_q.dest;

endmodule

// File: tb/tb_dispatch_unit.sv
// Directed bench for dispatch_unit.
// Hand-computed vectors; every check goes through one task.
module tb_dispatch_unit;

  localparam int XLEN    = 32;
  localparam int TAG_W   = 4;
  localparam int OPT_W   = 6;
  localparam int NUM_CDB = 2;

  logic clk = 0;
  logic rst, flush;
  logic dec_valid, dec_ready;
  logic [XLEN-1:0] dec_pc, dec_imm;
  logic [OPT_W-1:0] dec_optype;
  logic dec_is_ls, dec_has_rd;
  logic [4:0] dec_rd, dec_rs1, dec_rs2;
  logic [4:0] rf_rs1, rf_rs2;
  logic [TAG_W-1:0] rf_q1, rf_q2;
  logic [XLEN-1:0] rf_v1, rf_v2;
  logic [TAG_W-1:0] rob_q1, rob_q2;
  logic rob_rdy1, rob_rdy2;
  logic [XLEN-1:0] rob_v1, rob_v2;
  logic rob_full, rob_alloc;
  logic [TAG_W-1:0] rob_alloc_tag;
  logic ren_en;
  logic [4:0] ren_rd;
  logic [TAG_W-1:0] ren_tag;
  logic [NUM_CDB-1:0] cdb_valid;
  logic [NUM_CDB*TAG_W-1:0] cdb_tag;
  logic [NUM_CDB*XLEN-1:0] cdb_val;
  logic rs_ready, lsb_ready;
  logic out_valid_rs, out_valid_lsb;
  logic [OPT_W-1:0] out_optype;
  logic [XLEN-1:0] out_pc, out_imm, out_vj, out_vk;
  logic [TAG_W-1:0] out_qj, out_qk, out_dest;

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dispatch_unit #(
    .XLEN(XLEN), .TAG_W(TAG_W),
    .OPT_W(OPT_W), .NUM_CDB(NUM_CDB)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_pc(dec_pc), .dec_optype(dec_optype),
    .dec_is_ls(dec_is_ls), .dec_rd(dec_rd),
    .dec_has_rd(dec_has_rd), .dec_rs1(dec_rs1),
    .dec_rs2(dec_rs2), .dec_imm(dec_imm),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .rf_q1(rf_q1), .rf_q2(rf_q2),
    .rf_v1(rf_v1), .rf_v2(rf_v2),
    .rob_q1(rob_q1), .rob_q2(rob_q2),
    .rob_rdy1(rob_rdy1), .rob_rdy2(rob_rdy2),
    .rob_v1(rob_v1), .rob_v2(rob_v2),
    .rob_full(rob_full), .rob_alloc(rob_alloc),
    .rob_alloc_tag(rob_alloc_tag),
    .ren_en(ren_en), .ren_rd(ren_rd), .ren_tag(ren_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_val(cdb_val),
    .rs_ready(rs_ready), .lsb_ready(lsb_ready),
    .out_valid_rs(out_valid_rs),
    .out_valid_lsb(out_valid_lsb),
    .out_optype(out_optype), .out_pc(out_pc),
    .out_imm(out_imm), .out_qj(out_qj), .out_qk(out_qk),
    .out_vj(out_vj), .out_vk(out_vk), .out_dest(out_dest)
  );

  task automatic check(
    input string tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; flush = 0;
    dec_valid = 0; dec_pc = 0; dec_imm = 0;
    dec_optype = 0; dec_is_ls = 0; dec_has_rd = 0;
    dec_rd = 0; dec_rs1 = 0; dec_rs2 = 0;
    rf_q1 = 0; rf_q2 = 0; rf_v1 = 0; rf_v2 = 0;
    rob_rdy1 = 0; rob_rdy2 = 0; rob_v1 = 0; rob_v2 = 0;
    rob_full = 0; rob_alloc_tag = 1;
    cdb_valid = 0; cdb_tag = 0; cdb_val = 0;
    rs_ready = 1; lsb_ready = 1;

    tick();
    tick();
    check("rst_dec_ready", dec_ready, 0);
    check("rst_valid_rs", out_valid_rs, 0);
    check("rst_valid_lsb", out_valid_lsb, 0);
    check("rst_dest", out_dest, 0);

    // ALU op, both operands from regfile
    rst = 0;
    dec_valid = 1; dec_optype = 6'd5; dec_pc = 32'h100;
    dec_rd = 5'd4; dec_has_rd = 1;
    dec_rs1 = 5'd9; dec_rs2 = 5'd10;
    rf_v1 = 5; rf_v2 = 7; rob_alloc_tag = 3;
    rf_q1 = 4'd1;
    #1;
    check("rf_rs1", rf_rs1, 9);
    check("rob_q1", rob_q1, 1);
    rf_q1 = 0;
    #1;
    check("alu_ready", dec_ready, 1);
    check("alu_alloc", rob_alloc, 1);
    check("alu_ren_en", ren_en, 1);
    check("alu_ren_rd", ren_rd, 4);
    check("alu_ren_tag", ren_tag, 3);
    tick();
    dec_valid = 0;
    check("alu_valid_rs", out_valid_rs, 1);
    check("alu_vj", out_vj, 5);
    check("alu_vk", out_vk, 7);
    check("alu_qj", out_qj, 0);
    check("alu_qk", out_qk, 0);
    check("alu_dest", out_dest, 3);
    check("alu_pc", out_pc, 32'h100);
    tick();
    check("alu_drained", out_valid_rs, 0);

    // Load stalled on LSB, woken by CDB channel 1
    lsb_ready = 0; rs_ready = 1;
    dec_valid = 1; dec_is_ls = 1; dec_rd = 5'd7;
    rf_q1 = 2; rob_rdy1 = 0; rf_q2 = 0; rf_v2 = 8;
    rob_alloc_tag = 5;
    tick();
    rob_alloc_tag = 6;
    for (int c = 0; c < 3; c++) begin
      check("ld_valid_lsb", out_valid_lsb, 1);
      check("ld_valid_rs", out_valid_rs, 0);
      check("ld_qj", out_qj, 2);
      check("ld_ready", dec_ready, 0);
      check("ld_no_alloc", rob_alloc, 0);
      tick();
    end
    cdb_valid = 2'b10;
    cdb_tag = {4'd2, 4'd0};
    cdb_val = {32'h99, 32'h0};
    tick();
    cdb_valid = 0;
    check("ld_wake_qj", out_qj, 0);
    check("ld_wake_vj", out_vj, 32'h99);
    check("ld_dest", out_dest, 5);
    check("ld_still", out_valid_lsb, 1);
    dec_valid = 0; lsb_ready = 1;
    #1;
    check("ld_fire_ready", dec_ready, 1);
    tick();
    check("ld_empty", out_valid_lsb, 0);

    // CDB beats ROB at accept
    dec_valid = 1; dec_is_ls = 0;
    rf_q1 = 6; rob_rdy1 = 1; rob_v1 = 32'h22;
    rf_q2 = 9; rob_rdy2 = 0;
    cdb_valid = 2'b01;
    cdb_tag = {4'd0, 4'd6};
    cdb_val = {32'h0, 32'h11};
    rob_alloc_tag = 8;
    tick();
    check("fwd_vj", out_vj, 32'h11);
    check("fwd_qj", out_qj, 0);
    check("fwd_qk", out_qk, 9);
    check("fwd_vk", out_vk, 0);
    // both channels match: channel 0 wins
    cdb_valid = 2'b11;
    cdb_tag = {4'd6, 4'd6};
    cdb_val = {32'h44, 32'h33};
    tick();
    check("tie_vj", out_vj, 32'h33);
    // ROB-ready path
    cdb_valid = 0;
    tick();
    check("rob_vj", out_vj, 32'h22);
    rob_rdy1 = 0; rf_q2 = 0;

    // Back-to-back ALU ops
    rf_q1 = 0;
    for (int i = 1; i <= 4; i++) begin
      rob_alloc_tag = TAG_W'(i);
      rf_v1 = 32'(10 + i);
      #1;
      check("b2b_ready", dec_ready, 1);
      tick();
      check("b2b_valid", out_valid_rs, 1);
      check("b2b_dest", out_dest, 64'(i));
      check("b2b_vj", out_vj, 64'(10 + i));
    end
    rob_full = 1;
    #1;
    check("full_ready", dec_ready, 0);
    check("full_alloc", rob_alloc, 0);
    check("full_ren", ren_en, 0);
    tick();
    check("full_empty", out_valid_rs, 0);
    rob_full = 0;

    // x0 never renamed; slot then stalls on RS
    dec_rd = 0; dec_has_rd = 1; rob_alloc_tag = 10;
    #1;
    check("x0_ren", ren_en, 0);
    check("x0_alloc", rob_alloc, 1);
    rs_ready = 0;
    tick();
    check("x0_held", out_valid_rs, 1);

    // Flush while stalled, with a valid decode
    flush = 1; dec_rd = 5; rob_alloc_tag = 11;
    #1;
    check("fl_ready", dec_ready, 0);
    check("fl_ren", ren_en, 0);
    check("fl_alloc", rob_alloc, 0);
    tick();
    flush = 0; dec_valid = 0;
    check("fl_empty", out_valid_rs, 0);

    // Reset while FULL
    dec_valid = 1; dec_pc = 32'h200; rob_alloc_tag = 7;
    rf_v1 = 32'h55;
    tick();
    dec_valid = 0;
    check("pre_rst_full", out_valid_rs, 1);
    rst = 1;
    #1;
    check("rst_ready2", dec_ready, 0);
    tick();
    check("rst2_valid", out_valid_rs, 0);
    check("rst2_dest", out_dest, 0);
    check("rst2_vj", out_vj, 0);
    check("rst2_pc", out_pc, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
